// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide sequencer owning HI/LO for the E stage
// Optional madd/msub (ops 7/8) are compiled in when MDU_MADD_EN is defined.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic        cancel,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] out,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        madd_op;
   logic        mul_op;
   logic        div_op;

`ifdef MDU_MADD_EN
   assign madd_op = (op == 4'd7) || (op == 4'd8);
`else
   assign madd_op = 1'b0;
`endif
   assign mul_op = (op == 4'd1) || (op == 4'd2) || madd_op;
   assign div_op = (op == 4'd3) || (op == 4'd4);

   logic [63:0] prod_s, prod_u;
   logic [31:0] abs_a, abs_b, dvs_s, dvs_u;
   logic [31:0] quo_s, rem_s, quo_u, rem_u;
   logic [31:0] q_s, r_s;

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
   always_comb begin
      prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u = {32'd0, a_q} * {32'd0, b_q};
      abs_a  = a_q[31] ? (32'd0 - a_q) : a_q;
      abs_b  = b_q[31] ? (32'd0 - b_q) : b_q;
      dvs_s  = (abs_b == 32'd0) ? 32'd1 : abs_b;
      dvs_u  = (b_q == 32'd0) ? 32'd1 : b_q;
      quo_s  = abs_a / dvs_s;
      rem_s  = abs_a % dvs_s;
      quo_u  = a_q / dvs_u;
      rem_u  = a_q % dvs_u;
      q_s    = (a_q[31] ^ b_q[31]) ? (32'd0 - quo_s) : quo_s;
      r_s    = a_q[31] ? (32'd0 - rem_s) : rem_s;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (!cancel) begin
               if (start && (mul_op || div_op)) begin
                  a_d     = A;
                  b_d     = B;
                  op_d    = op;
                  cnt_d   = div_op ? 32'(DIV_CYCLES - 1) : 32'(MULT_CYCLES - 1);
                  state_d = div_op ? DIV : MUL;
               end else if (op == 4'd9) begin
                  hi_d = A;
               end else if (op == 4'd10) begin
                  lo_d = A;
               end
            end
         end
         MUL: begin
            if (cnt_q == 32'd0) begin
               state_d = IDLE;
               case (op_q)
                  4'd1:    {hi_d, lo_d} = prod_s;
                  4'd2:    {hi_d, lo_d} = prod_u;
                  4'd7:    {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                  4'd8:    {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         DIV: begin
            if (cnt_q == 32'd0) begin
               state_d = IDLE;
               // Divide by zero still burns the full latency but leaves HI/LO alone.
               if (b_q != 32'd0) begin
                  if (op_q == 4'd3) {hi_d, lo_d} = {r_s, q_s};
                  else              {hi_d, lo_d} = {rem_u, quo_u};
               end
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 32'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         op_q    <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      out = 32'd0;
      if (op == 4'd5)      out = hi_q;
      else if (op == 4'd6) out = lo_q;
   end

   assign busy = (state_q != IDLE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed and random checks of mdu_ctrl against a cycle-level arithmetic model
module tb_mdu_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset, start, cancel;
   logic [3:0]  op;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] out, hi, lo;

   always #5 clk = ~clk;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
      .A(A), .B(B), .busy(busy), .out(out), .hi(hi), .lo(lo)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: remaining busy cycles plus the result to commit when they run out.
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   int          m_left = 0;
   logic        m_pend = 1'b0;
   logic [63:0] m_res = 64'd0;

   function automatic bit legal(input logic [3:0] o);
`ifdef MDU_MADD_EN
      return (o inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8});
`else
      return (o inside {4'd1, 4'd2, 4'd3, 4'd4});
`endif
   endfunction

   task automatic model_edge();
      longint      sa, sb, q, r;
      logic [63:0] ua, ub;
      if (reset) begin
         m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_pend = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && m_pend) {m_hi, m_lo} = m_res;
      end else if (!cancel) begin
         if (start && legal(op)) begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            ua = {32'd0, A};
            ub = {32'd0, B};
            m_pend = 1'b1;
            m_left = (op == 4'd3 || op == 4'd4) ? DC : MC;
            case (op)
               4'd1: m_res = 64'(sa * sb);
               4'd2: m_res = ua * ub;
               4'd3: begin
                  if (B == 32'd0) m_pend = 1'b0;
                  else begin
                     q = sa / sb;
                     r = sa % sb;
                     m_res = {r[31:0], q[31:0]};
                  end
               end
               4'd4: begin
                  if (B == 32'd0) m_pend = 1'b0;
                  else m_res = {32'(ua % ub), 32'(ua / ub)};
               end
               4'd7: m_res = {m_hi, m_lo} + 64'(sa * sb);
               4'd8: m_res = {m_hi, m_lo} - 64'(sa * sb);
               default: m_pend = 1'b0;
            endcase
         end else if (op == 4'd9) begin
            m_hi = A;
         end else if (op == 4'd10) begin
            m_lo = A;
         end
      end
   endtask

   task automatic step(input logic r, input logic s, input logic c, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b);
      reset = r; start = s; cancel = c; op = o; A = a; B = b;
      @(posedge clk);
      model_edge();
      #1;
      check("busy", 32'(busy), 32'(m_left > 0));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("out", out, (o == 4'd5) ? m_hi : (o == 4'd6) ? m_lo : 32'd0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
   endtask

   task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int n);
      step(1'b0, 1'b1, 1'b0, o, a, b);
      n = int'(busy);
      for (int i = 0; i < 64 && busy; i++) begin
         idle();
         n += int'(busy);
      end
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   int n;

   initial begin
      reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
      step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);

      launch(4'd1, 32'hFFFF_FFFF, 32'd2, n);
      check("mult_cycles", n, MC);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFE);

      launch(4'd2, 32'hFFFF_FFFF, 32'd2, n);
      check("multu_hi", hi, 32'h0000_0001);
      check("multu_lo", lo, 32'hFFFF_FFFE);

      launch(4'd3, 32'hFFFF_FFF9, 32'd2, n);
      check("div_cycles", n, DC);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);

      launch(4'd3, 32'hFFFF_FFF9, 32'd0, n);
      check("div0_cycles", n, DC);
      check("div0_lo", lo, 32'hFFFF_FFFD);
      check("div0_hi", hi, 32'hFFFF_FFFF);

      step(1'b0, 1'b0, 1'b1, 4'd10, 32'h1234_5678, 32'd0);
      check("mtlo_cancel", lo, 32'hFFFF_FFFD);
      step(1'b0, 1'b0, 1'b0, 4'd10, 32'h1234_5678, 32'd0);
      check("mtlo", lo, 32'h1234_5678);

      step(1'b0, 1'b1, 1'b1, 4'd3, 32'd100, 32'd7);
      check("div_cancel_busy", 32'(busy), 32'd0);

      step(1'b0, 1'b1, 1'b0, 4'd2, 32'd3, 32'd4);
      step(1'b0, 1'b0, 1'b0, 4'd9, 32'h0000_DEAD, 32'd0);
      for (int i = 0; i < 64 && busy; i++) idle();
      check("multu_hi_blocked", hi, 32'd0);
      check("multu_lo", lo, 32'd12);
      step(1'b0, 1'b0, 1'b0, 4'd6, 32'd0, 32'd0);
      check("mflo_out", out, 32'd12);
      step(1'b0, 1'b0, 1'b0, 4'd5, 32'd0, 32'd0);
      check("mfhi_out", out, 32'd0);

      launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 32'd0);

      launch(4'd4, 32'hFFFF_FFF9, 32'd2, n);
      check("divu_lo", lo, 32'h7FFF_FFFC);
      check("divu_hi", hi, 32'd1);

      step(1'b0, 1'b1, 1'b0, 4'd3, 32'd50, 32'd3);
      idle();
      idle();
      idle();
      step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_hi", hi, 32'd0);
      check("rst_mid_lo", lo, 32'd0);
      for (int i = 0; i < DC; i++) idle();
      check("rst_mid_lo_after", lo, 32'd0);

`ifdef MDU_MADD_EN
      step(1'b0, 1'b0, 1'b0, 4'd10, 32'd5, 32'd0);
      step(1'b0, 1'b0, 1'b0, 4'd9, 32'd0, 32'd0);
      launch(4'd7, 32'd3, 32'd4, n);
      check("madd_cycles", n, MC);
      check("madd_lo", lo, 32'd17);
      check("madd_hi", hi, 32'd0);
      launch(4'd8, 32'd1, 32'd18, n);
      check("msub_hi", hi, 32'hFFFF_FFFF);
      check("msub_lo", lo, 32'hFFFF_FFFF);
`else
      step(1'b0, 1'b0, 1'b0, 4'd10, 32'd5, 32'd0);
      step(1'b0, 1'b1, 1'b0, 4'd7, 32'd3, 32'd4);
      check("madd_off_busy", 32'(busy), 32'd0);
      check("madd_off_lo", lo, 32'd5);
      step(1'b0, 1'b1, 1'b0, 4'd8, 32'd3, 32'd4);
      check("msub_off_busy", 32'(busy), 32'd0);
      check("msub_off_lo", lo, 32'd5);
`endif

      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)),
              rnd_val(), rnd_val());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
